// File: rtl/bnn_xnor_popcount_scan_pkg.sv
// Shared constants, state encoding and weight bit-index convention for the
// binarized XNOR/popcount window scanner and its weight memory writer.
package bnn_xnor_popcount_scan_pkg;

    localparam int CH    = 4;
    localparam int WIN   = 9;
    localparam int CNT_W = 6;
    localparam int POS_W = 4;
    localparam int SEL_W = 2;
    localparam int WT_W  = CH * WIN;
    localparam int IDX_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Weight bit for position p, channel c lives at p*CH+c.
    function automatic logic [IDX_W-1:0] weight_idx(input logic [POS_W-1:0] p,
                                                    input logic [SEL_W-1:0] c);
        return IDX_W'(p) * IDX_W'(CH) + IDX_W'(c);
    endfunction

endpackage

// File: rtl/bnn_scan_index_counter.sv
// Nested channel (inner) / position (outer) counter for the window scan.
// Wraps back to c=0, p=0 after the last step, so idle outputs read as zero.
module bnn_scan_index_counter
    import bnn_xnor_popcount_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [SEL_W-1:0] c,
    output logic [POS_W-1:0] p,
    output logic             last
);

    logic [SEL_W-1:0] c_reg;
    logic [POS_W-1:0] p_reg;
    logic             c_wrap;
    logic             p_wrap;

    assign c_wrap = (c_reg == SEL_W'(CH - 1));
    assign p_wrap = (p_reg == POS_W'(WIN - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            c_reg <= '0;
            p_reg <= '0;
        end else if (en) begin
            if (c_wrap) begin
                c_reg <= '0;
                p_reg <= p_wrap ? '0 : p_reg + POS_W'(1);
            end else begin
                c_reg <= c_reg + SEL_W'(1);
            end
        end
    end

    assign c    = c_reg;
    assign p    = p_reg;
    assign last = c_wrap && p_wrap;

endmodule

// File: rtl/bnn_xnor_popcount_scan.sv
// Scans one CH x WIN binary window through the 4:1 channel mux, XNORs each
// bit against the latched weight, popcounts the matches and thresholds them.
module bnn_xnor_popcount_scan
    import bnn_xnor_popcount_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WT_W-1:0]  weight,
    input  logic [CNT_W-1:0] thr,
    output logic [SEL_W-1:0] sel,
    output logic [POS_W-1:0] pos_idx,
    input  logic             in_bit,
    output logic             busy,
    output logic             valid,
    output logic             act,
    output logic [CNT_W-1:0] count
);

    state_t           state_reg,  state_next;
    logic [WT_W-1:0]  weight_reg, weight_next;
    logic [CNT_W-1:0] thr_reg,    thr_next;
    logic [CNT_W-1:0] acc_reg,    acc_next;
    logic [CNT_W-1:0] count_reg,  count_next;
    logic             act_reg,    act_next;
    logic             valid_reg,  valid_next;

    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_last;
    logic [SEL_W-1:0] cnt_c;
    logic [POS_W-1:0] cnt_p;
    logic             match;

    bnn_scan_index_counter u_index (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .c     (cnt_c),
        .p     (cnt_p),
        .last  (cnt_last)
    );

    // in_bit is combinational from sel/pos_idx and consumed in the same cycle.
    assign match = ~(in_bit ^ weight_reg[weight_idx(cnt_p, cnt_c)]);

    always_comb begin
        state_next  = state_reg;
        weight_next = weight_reg;
        thr_next    = thr_reg;
        acc_next    = acc_reg;
        count_next  = count_reg;
        act_next    = act_reg;
        valid_next  = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    weight_next = weight;
                    thr_next    = thr;
                    acc_next    = '0;
                    cnt_clr     = 1'b1;
                    state_next  = RUN;
                end
            end
            RUN: begin
                cnt_en   = 1'b1;
                acc_next = acc_reg + CNT_W'(match);
                if (cnt_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                valid_next = 1'b1;
                count_next = acc_reg;
                act_next   = (acc_reg >= thr_reg);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            weight_reg <= '0;
            thr_reg    <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
            act_reg    <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            weight_reg <= weight_next;
            thr_reg    <= thr_next;
            acc_reg    <= acc_next;
            count_reg  <= count_next;
            act_reg    <= act_next;
            valid_reg  <= valid_next;
        end
    end

    assign sel     = cnt_c;
    assign pos_idx = cnt_p;
    assign busy    = (state_reg != IDLE);
    assign valid   = valid_reg;
    assign act     = act_reg;
    assign count   = count_reg;

endmodule

// File: tb/tb_bnn_xnor_popcount_scan.sv
// Directed bench for the XNOR/popcount window scanner with a result scoreboard.
module tb_bnn_xnor_popcount_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [35:0] weight;
    logic [5:0]  thr;
    logic [1:0]  sel;
    logic [3:0]  pos_idx;
    logic        in_bit;
    logic        busy;
    logic        valid;
    logic        act;
    logic [5:0]  count;

    logic [35:0] feat_vec;
    logic [6:0]  exp_q[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    bnn_xnor_popcount_scan dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .weight  (weight),
        .thr     (thr),
        .sel     (sel),
        .pos_idx (pos_idx),
        .in_bit  (in_bit),
        .busy    (busy),
        .valid   (valid),
        .act     (act),
        .count   (count)
    );

    always #5 clk = ~clk;

    // Upstream feature buffer + 4:1 mux model.
    always_comb begin
        int idx;
        idx    = int'(pos_idx) * 4 + int'(sel);
        in_bit = 1'b0;
        if (pos_idx < 4'd9) in_bit = feat_vec[idx];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic run_window(input logic [35:0] w, input logic [5:0] t,
                              input logic [35:0] f, input logic [5:0] exp_cnt,
                              input logic exp_act, input bit inject, input int abort_at);
        int         lat;
        logic [6:0] e;
        @(negedge clk);
        feat_vec = f;
        weight   = w;
        thr      = t;
        start    = 1'b1;
        if (abort_at < 0) exp_q.push_back({exp_act, exp_cnt});
        @(posedge clk);
        #1;
        start  = 1'b0;
        weight = ~w;
        thr    = ~t;
        lat    = -1;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (j < 36) begin
                check("sel", 32'(sel), 32'(j % 4));
                check("pos_idx", 32'(pos_idx), 32'(j / 4));
                check("busy_run", 32'(busy), 32'd1);
            end
            if (j == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_valid", 32'(valid), 32'd0);
                check("abort_sel", 32'(sel), 32'd0);
                check("abort_pos", 32'(pos_idx), 32'd0);
                check("abort_count", 32'(count), 32'd0);
                check("abort_act", 32'(act), 32'd0);
                @(negedge clk);
                check("abort_no_valid", 32'(valid), 32'd0);
                break;
            end
            if (valid) begin
                lat = j;
                break;
            end
            start = inject && (j == 10 || j == 36);
        end
        start = 1'b0;
        if (abort_at < 0) begin
            check("latency", lat, 32'd37);
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                $display("window w=%h thr=%0d count=%0d act=%0d exp_count=%0d exp_act=%0d",
                         w, t, count, act, e[5:0], e[6]);
                check("count", 32'(count), 32'(e[5:0]));
                check("act", 32'(act), 32'(e[6]));
                @(negedge clk);
                check("valid_pulse", 32'(valid), 32'd0);
                check("idle_busy", 32'(busy), 32'd0);
                check("count_hold", 32'(count), 32'(e[5:0]));
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        weight   = '0;
        thr      = '0;
        feat_vec = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_pos", 32'(pos_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_act", 32'(act), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;

        run_window({36{1'b1}}, 6'd18, {36{1'b1}}, 6'd36, 1'b1, 1'b0, -1);
        run_window({36{1'b1}}, 6'd1,  36'h0,      6'd0,  1'b0, 1'b0, -1);
        run_window({36{1'b1}}, 6'd0,  36'h0,      6'd0,  1'b1, 1'b0, -1);
        run_window({36{1'b1}}, 6'd18, 36'h0_0003_FFFF, 6'd18, 1'b1, 1'b0, -1);
        run_window({36{1'b1}}, 6'd18, 36'h0_0001_FFFF, 6'd17, 1'b0, 1'b0, -1);
        run_window(36'h4_4444_4444, 6'd18, 36'h4_4444_4444, 6'd36, 1'b1, 1'b0, -1);
        run_window(36'h0,           6'd18, 36'h4_4444_4444, 6'd27, 1'b1, 1'b0, -1);
        run_window({36{1'b1}}, 6'd37, {36{1'b1}}, 6'd36, 1'b0, 1'b0, -1);

        // Starts during RUN and DONE must not launch a second window.
        run_window({36{1'b1}}, 6'd18, {36{1'b1}}, 6'd36, 1'b1, 1'b1, -1);
        repeat (3) begin
            @(negedge clk);
            check("no_restart_busy", 32'(busy), 32'd0);
            check("no_restart_valid", 32'(valid), 32'd0);
        end

        run_window({36{1'b1}}, 6'd18, 36'h0, 6'd0, 1'b0, 1'b0, 20);
        run_window({36{1'b1}}, 6'd18, {36{1'b1}}, 6'd36, 1'b1, 1'b0, -1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bnn_xnor_popcount_scan.md
Name: bnn_xnor_popcount_scan

Overview:
- Downstream consumer of the 4:1 channel multiplexer in the binarized conv datapath.
- Drives the mux select and a window-position index, then consumes the selected feature bit serially.
- Each consumed bit is XNORed with a latched binary weight, and the matches are popcounted over a full window.
- The count is compared against a latched threshold to produce one binary activation per window.

Parameters:
- CH, 4, channels per position; fixed to match the 4:1 mux (select width 2).
- WIN, 9, window positions per activation (3x3 kernel).
- CNT_W, 6, popcount width, equal to clog2(CH*WIN+1).
- POS_W, 4, position index width, equal to clog2(WIN).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request one window evaluation; honoured only in IDLE
- weight  in  CH*WIN  binary weights, bit index p*CH+c; latched on accepted start
- thr  in  CNT_W  activation threshold; latched on accepted start
- sel  out  2  channel select to mux sign input
- pos_idx  out  POS_W  window position to the upstream feature buffer
- in_bit  in  1  mux outMap; combinational from sel/pos_idx, sampled in the same cycle
- busy  out  1  high in RUN and DONE
- valid  out  1  one-cycle pulse with the result
- act  out  1  activation result: count >= thr
- count  out  CNT_W  final popcount

Behaviour:
- States: IDLE, RUN, DONE. Reset (rst_n=0 at a clock edge) forces IDLE regardless of current state.
- Reset values: sel=0, pos_idx=0, busy=0, valid=0, act=0, count=0. Internal accumulator and step counter are also 0.
- IDLE:
  - On start=1, latch weight and thr, clear the accumulator, clear c=0 and p=0, and go to RUN.
  - Otherwise hold. act and count keep the last result.
- RUN:
  - sel=c and pos_idx=p are driven from registers.
  - Each cycle, acc += ~(in_bit ^ weight_q[p*CH+c]).
  - c increments 0..CH-1 and wraps to 0 while p increments. Channel is the inner loop, position the outer loop.
  - After the step with p=WIN-1 and c=CH-1, go to DONE. RUN lasts exactly CH*WIN = 36 cycles.
- DONE:
  - For one cycle, valid=1, count=final acc, act=(final acc >= thr_q). Then go to IDLE.
  - count and act are registered and stable from DONE until the next accepted start completes.
- Latency: start sampled at edge k puts valid high in the cycle after edge k+37.
- start while busy (RUN or DONE) is ignored. There is no queuing.
- Width rules:
  - acc is CNT_W bits and cannot overflow (maximum 36 < 64).
  - Compare is unsigned. thr=0 gives act=1 always. thr > 36 gives act=0 always.
- Weight and thr changes after acceptance have no effect on the current window.
- Reset during RUN discards the partial accumulation. No valid is produced, and the next start runs cleanly.
- sel and pos_idx return to 0 in IDLE and DONE.

Decomposition:
- Shared package holds:
  - CH, WIN, CNT_W, POS_W constants.
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The weight bit-index convention p*CH+c, also used by the weight memory writer.
- One natural sub-module, bnn_scan_index_counter:
  - Nested channel/position counter with clear and enable.
  - Outputs c, p and a last flag.
- The FSM, XNOR/accumulate and threshold compare stay in the top.

Test Plan:
- All weight bits 1, feature buffer all 1s, thr=18 -> valid once after 37 cycles; count=36, act=1; sel sequence 0,1,2,3 repeated 9 times with pos_idx 0..8.
- All weights 1, features all 0, thr=1 -> count=0, act=0. Same data with thr=0 -> act=1.
- Threshold boundary with thr=18: feature pattern matching exactly 18 of 36 weights -> act=1; a pattern matching 17 -> count=17, act=0.
- Only channel 2 set at every position, weights 0x444444444 -> count=36; weights all 0 -> count=27 (checks p*CH+c indexing and sel order).
- start pulsed at RUN cycle 10 and in the DONE cycle -> ignored; exactly one valid; the next window starts only on a start seen in IDLE.
- rst_n=0 for one edge at RUN cycle 20 -> IDLE next cycle with all outputs 0, no valid; a fresh start with all-match data -> count=36 after 37 cycles.
